prefetch_queue: RTL and testbench
=================================

Name: prefetch_queue

Overview:
- Parametrised successor to the single-word fetch stage: decouples instruction memory from the decoder with a circular byte queue.
- Issues FETCH_BYTES-wide reads ahead of execution over a req/valid handshake that tolerates any memory latency.
- Presents whole variable-length 6502 instructions (opcode plus 0–2 operand bytes) to the decoder, with their PCs.
- A branch flush redirects fetch and discards stale bytes and any in-flight read.

Parameters:
ADDR_W, 16, memory address width.
FETCH_BYTES, 3, bytes returned per memory read (≥3).
DEPTH, 8, queue capacity in bytes; power of two, ≥ 2*FETCH_BYTES.
RESET_PC, 16'h8000, fetch and instruction PC after reset.

Ports:
clk_i  in  1  clock
rstn_i  in  1  async reset, active low
flush_i  in  1  redirect request (taken branch/jump)
flush_pc_i  in  ADDR_W  redirect target
mem_req_o  out  1  read request
mem_addr_o  out  ADDR_W  read address, byte-aligned, no alignment requirement
mem_valid_i  in  1  read data valid; completes the outstanding request
mem_data_i  in  FETCH_BYTES*8  read data; byte k at bits [8k+7:8k] = mem[addr+k]
instr_valid_o  out  1  complete instruction at head
instr_ready_i  in  1  decoder consumes head instruction
opcode_o  out  8  head opcode
operand_o  out  16  operand bytes, little-endian; absent bytes read 0
instr_len_o  out  2  instruction length, 1..3
instr_pc_o  out  ADDR_W  address of head opcode
count_o  out  $clog2(DEPTH)+1  bytes held

Behaviour:
- Clock and reset: one clock `clk_i`; reset `rstn_i` is asynchronous and active low.
- Reset values:
  - count 0; head and tail pointers 0; state IDLE.
  - fetch_addr = instr_pc = RESET_PC.
  - mem_req_o = 0, instr_valid_o = 0, opcode_o = 0, operand_o = 0, instr_len_o = 0.
- Fetch FSM states: IDLE, REQ, DRAIN.
  - mem_req_o = 1 in REQ and DRAIN. mem_addr_o = fetch_addr register.
  - IDLE→REQ when free (DEPTH − count) ≥ FETCH_BYTES. First request goes out the cycle after reset release.
  - REQ with mem_valid_i:
    - write FETCH_BYTES bytes at tail; fetch_addr += FETCH_BYTES, wrapping mod 2^ADDR_W.
    - next state REQ if next-cycle free ≥ FETCH_BYTES, else IDLE (back-to-back reads allowed).
  - REQ without mem_valid_i: hold; mem_addr_o stays stable.
  - mem_valid_i while mem_req_o = 0 is ignored.
- Flush (priority over push and pop in the same cycle):
  - count, head and tail cleared; fetch_addr = instr_pc = flush_pc_i.
  - In REQ, or in DRAIN without mem_valid_i: go to DRAIN. Keep mem_req_o high on the old address until mem_valid_i; discard that data, then go to IDLE.
  - In DRAIN with mem_valid_i in the same cycle: the response is discarded and the state goes to IDLE.
  - In IDLE: stay IDLE; the normal IDLE→REQ rule applies next cycle.
  - Only one request is ever outstanding.
- Head decode:
  - len = op_len(head byte), from the package 6502 length table.
  - instr_valid_o = (count ≥ 1) && (count ≥ len); combinational from registered storage.
  - operand_o = {head+2, head+1} masked by len.
- Pop: when instr_valid_o && instr_ready_i, remove len bytes, head += len mod DEPTH, instr_pc += len mod 2^ADDR_W.
- Simultaneous push and pop: both apply; count_next = count + FETCH_BYTES − len.
- Free-space check uses the registered count, so a push never overflows even with no pop.
- Latency: mem_valid_i at cycle t → bytes visible and instr_valid_o possible at t+1.
- Pointer wrap-around: indices taken mod DEPTH; an instruction may straddle the queue end.
- Reset mid-transaction: state returns to IDLE; a late mem_valid_i is ignored because mem_req_o = 0.

Decomposition:
- Package (shared cpu package) holds:
  - `fetch_state_t` enum {IDLE, REQ, DRAIN};
  - the `op_len(opcode)` function covering all 6502 addressing modes (implied/accumulator 1; imm/zp/zp,X/zp,Y/(zp,X)/(zp),Y/relative 2; abs/abs,X/abs,Y/indirect 3);
  - `BYTE` constant.
- Sub-module `byte_ring_buffer`: DEPTH-byte storage with multi-byte push and variable-length pop, plus pointers and count.
- Fetch FSM and instruction framing stay in prefetch_queue.

Test Plan (DEPTH=8, FETCH_BYTES=3, RESET_PC=8000):
- Release reset → cycle 1: mem_req_o=1, mem_addr_o=8000. Drive valid, data 24'h8D44A9 → next cycle instr_valid_o=1, opcode A9, operand 0044, len 2, pc 8000.
- Straddle: stream A9 44 8D | 00 02 EA, ready high throughout → LDA at 8000, then STA (operand 0200, len 3) valid only after the 2nd word, pc 8002, then NOP (len 1, operand 0) at 8005.
- Backpressure: instr_ready_i=0 and mem_valid_i always 1 → fills to count 6; mem_req_o deasserts (free 2 < 3). Set ready=1 → requests resume; no byte lost or duplicated.
- Flush during an outstanding request (mem_valid_i delayed 4 cycles), flush_pc=C000 → mem_addr_o held at old value until valid; that data discarded; next request addr C000; first instruction pc C000.
- Flush in the same cycle as mem_valid_i and pop → count 0, instr_valid_o=0 next cycle, fetch restarts at flush_pc_i.
- Wrap-around: RESET_PC=FFFE, stream 3-byte words → fetch_addr wraps to 0001; an instruction at FFFF has pc FFFF and the next pc wraps to 0000/0001 correctly.

Source files
------------

// File: rtl/prefetch_queue_pkg.sv
// Shared CPU fetch definitions: fetch FSM states and the 6502 instruction length table.
package prefetch_queue_pkg;

    localparam int BYTE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Length from the opcode's low nibble, which selects the addressing-mode column.
    function automatic logic [1:0] op_len(input logic [7:0] opcode);
        logic [1:0] len;
        len = 2'd1;
        case (opcode[3:0])
            4'h0: begin
                if (opcode[4])             len = 2'd2;
                else if (opcode == 8'h20)  len = 2'd3;
                else if (opcode[7])        len = 2'd2;
                else                       len = 2'd1;
            end
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: len = 2'd2;
            4'h2:       len = (opcode[7] && !opcode[4]) ? 2'd2 : 2'd1;
            4'h8, 4'hA: len = 2'd1;
            4'h9, 4'hB: len = opcode[4] ? 2'd3 : 2'd2;
            default:    len = 2'd3;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/prefetch_queue_byte_ring_buffer.sv
// Circular byte store: fixed-width push at the tail, variable-length pop at the head.
module byte_ring_buffer
    import prefetch_queue_pkg::*;
#(
    parameter int  DEPTH      = 8,
    parameter int  PUSH_BYTES = 3,
    localparam int PW         = $clog2(DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [PUSH_BYTES*BYTE-1:0] push_data_i,
    input  logic                       pop_i,
    input  logic [1:0]                 pop_len_i,
    output logic [CW-1:0]              count_o,
    output logic [3*BYTE-1:0]          peek_o
);

    logic [BYTE-1:0] mem_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;

    // Pointers are PW bits wide so they wrap at DEPTH for free.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) begin
            for (int k = 0; k < PUSH_BYTES; k++) begin
                mem_q[tail_q + PW'(k)] <= push_data_i[k*BYTE +: BYTE];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + PW'(PUSH_BYTES);
            if (pop_i)  head_q <= head_q + PW'(pop_len_i);
            count_q <= count_q + (push_i ? CW'(PUSH_BYTES) : '0) - (pop_i ? CW'(pop_len_i) : '0);
        end
    end

    always_comb begin
        peek_o = '0;
        for (int i = 0; i < 3; i++) begin
            peek_o[i*BYTE +: BYTE] = mem_q[head_q + PW'(i)];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Prefetching instruction queue: reads memory ahead into a byte ring and frames whole 6502 instructions.
//   state | meaning
//   IDLE  | no read outstanding; waits for room for one fetch word
//   REQ   | read outstanding at fetch address; data is pushed on mem_valid_i
//   DRAIN | read outstanding from before a flush; its data is dropped
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                FETCH_BYTES = 3,
    parameter int                DEPTH       = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'h8000,
    localparam int               CW          = $clog2(DEPTH) + 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        flush_i,
    input  logic [ADDR_W-1:0]           flush_pc_i,
    output logic                        mem_req_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    input  logic                        mem_valid_i,
    input  logic [FETCH_BYTES*BYTE-1:0] mem_data_i,
    output logic                        instr_valid_o,
    input  logic                        instr_ready_i,
    output logic [7:0]                  opcode_o,
    output logic [15:0]                 operand_o,
    output logic [1:0]                  instr_len_o,
    output logic [ADDR_W-1:0]           instr_pc_o,
    output logic [CW-1:0]               count_o
);

    localparam logic [CW:0] FILL_LIMIT = (CW+1)'(DEPTH - FETCH_BYTES);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [CW-1:0]     count;
    logic [3*BYTE-1:0] peek;
    logic [1:0]        len;
    logic              head_ok;
    logic              push;
    logic              pop;
    logic [CW:0]       count_after;

    byte_ring_buffer #(
        .DEPTH      (DEPTH),
        .PUSH_BYTES (FETCH_BYTES)
    ) u_ring (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clr_i       (flush_i),
        .push_i      (push),
        .push_data_i (mem_data_i),
        .pop_i       (pop),
        .pop_len_i   (len),
        .count_o     (count),
        .peek_o      (peek)
    );

    assign len     = op_len(peek[7:0]);
    assign head_ok = (count != '0) && (count >= CW'(len));
    assign push    = (state_q == REQ) && mem_valid_i && !flush_i;
    assign pop     = head_ok && instr_ready_i && !flush_i;

    assign count_after = {1'b0, count} + (push ? (CW+1)'(FETCH_BYTES) : '0)
                         - (pop ? (CW+1)'(len) : '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // A flush that coincides with the response completes that request, so no drain is needed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!flush_i && ({1'b0, count} <= FILL_LIMIT)) state_d = REQ;
            end
            REQ: begin
                if (flush_i)          state_d = mem_valid_i ? IDLE : DRAIN;
                else if (mem_valid_i) state_d = (count_after <= FILL_LIMIT) ? REQ : IDLE;
            end
            DRAIN: begin
                if (mem_valid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o     = (state_q == REQ) || (state_q == DRAIN);
        mem_addr_o    = (state_q == DRAIN) ? drain_addr_q : fetch_addr_q;
        instr_valid_o = head_ok;
        opcode_o      = '0;
        operand_o     = '0;
        instr_len_o   = '0;
        if (count != '0) begin
            opcode_o    = peek[7:0];
            instr_len_o = len;
            if (len >= 2'd2) operand_o[7:0]  = peek[15:8];
            if (len == 2'd3) operand_o[15:8] = peek[23:16];
        end
        instr_pc_o    = instr_pc_q;
        count_o       = count;
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        drain_addr_d = drain_addr_q;
        instr_pc_d   = instr_pc_q;
        if (flush_i) begin
            fetch_addr_d = flush_pc_i;
            instr_pc_d   = flush_pc_i;
            if (state_q == REQ) drain_addr_d = fetch_addr_q;
        end else begin
            if (push) fetch_addr_d = fetch_addr_q + ADDR_W'(FETCH_BYTES);
            if (pop)  instr_pc_d   = instr_pc_q + ADDR_W'(len);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_addr_q <= RESET_PC;
            drain_addr_q <= RESET_PC;
            instr_pc_q   <= RESET_PC;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            drain_addr_q <= drain_addr_d;
            instr_pc_q   <= instr_pc_d;
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with a byte-memory responder and an instruction scoreboard.
module tb_prefetch_queue;

    localparam int AW = 16;
    localparam int FB = 3;
    localparam int CW = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  op;
        logic [15:0] opd;
        logic [1:0]  len;
    } instr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstn, flush, mem_valid, ready, mem_req, ivalid;
    logic [AW-1:0]  flush_pc, mem_addr, pc;
    logic [FB*8-1:0] mem_data;
    logic [7:0]     opcode;
    logic [15:0]    operand;
    logic [1:0]     len;
    logic [CW-1:0]  count;

    logic           w_rstn, w_flush, w_mvalid, w_ready, w_req, w_ivalid;
    logic [AW-1:0]  w_flush_pc, w_addr, w_pc;
    logic [FB*8-1:0] w_mdata;
    logic [7:0]     w_opcode;
    logic [15:0]    w_operand;
    logic [1:0]     w_len;
    logic [CW-1:0]  w_count;

    instr_t     exp_q[$];
    logic [7:0] mem [0:65535];
    int         n_vec = 0;
    int         n_err = 0;
    logic       auto_mem = 1'b0;
    int         lat = 0;
    int         wcnt = 0;
    logic [15:0] wp;
    logic       found;

    prefetch_queue u_dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .flush_pc_i(flush_pc),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_valid_i(mem_valid), .mem_data_i(mem_data),
        .instr_valid_o(ivalid), .instr_ready_i(ready), .opcode_o(opcode), .operand_o(operand),
        .instr_len_o(len), .instr_pc_o(pc), .count_o(count)
    );

    prefetch_queue #(.RESET_PC(16'hFFFE)) u_w (
        .clk_i(clk), .rstn_i(w_rstn), .flush_i(w_flush), .flush_pc_i(w_flush_pc),
        .mem_req_o(w_req), .mem_addr_o(w_addr), .mem_valid_i(w_mvalid), .mem_data_i(w_mdata),
        .instr_valid_o(w_ivalid), .instr_ready_i(w_ready), .opcode_o(w_opcode), .operand_o(w_operand),
        .instr_len_o(w_len), .instr_pc_o(w_pc), .count_o(w_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] op, input logic [1:0] n, input logic [15:0] opd);
        instr_t e;
        mem[wp] = op;
        if (n >= 2'd2) mem[wp + 16'd1] = opd[7:0];
        if (n == 2'd3) mem[wp + 16'd2] = opd[15:8];
        e.pc  = wp;
        e.op  = op;
        e.len = n;
        e.opd = (n == 2'd3) ? opd : (n == 2'd2) ? {8'h00, opd[7:0]} : 16'h0000;
        exp_q.push_back(e);
        wp = wp + 16'(n);
    endtask

    task automatic gen(input int cnt);
        logic [7:0] op;
        logic [1:0] n;
        for (int i = 0; i < cnt; i++) begin
            case (i % 8)
                0: begin op = 8'hA9; n = 2'd2; end
                1: begin op = 8'h8D; n = 2'd3; end
                2: begin op = 8'hEA; n = 2'd1; end
                3: begin op = 8'hB1; n = 2'd2; end
                4: begin op = 8'hBD; n = 2'd3; end
                5: begin op = 8'h0A; n = 2'd1; end
                6: begin op = 8'hD0; n = 2'd2; end
                default: begin op = 8'h6C; n = 2'd3; end
            endcase
            put(op, n, 16'($urandom));
        end
    endtask

    // Memory model: answers the outstanding request after lat idle cycles.
    always @(posedge clk) begin
        #2;
        if (auto_mem) begin
            if (mem_req && wcnt >= lat) begin
                mem_valid = 1'b1;
                mem_data  = {mem[mem_addr + 16'd2], mem[mem_addr + 16'd1], mem[mem_addr]};
                wcnt      = 0;
            end else begin
                mem_valid = 1'b0;
                wcnt      = mem_req ? wcnt + 1 : 0;
            end
        end
    end

    always @(negedge clk) begin : mon
        instr_t e;
        if (rstn && ivalid && ready && !flush) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_underflow observed=pop_at_pc_%h expected=no_pop", pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", pc, e.pc);
                check("sb_opcode", opcode, e.op);
                check("sb_operand", operand, e.opd);
                check("sb_len", len, e.len);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 0; flush = 0; flush_pc = '0; mem_valid = 0; mem_data = '0; ready = 0;
        w_rstn = 0; w_flush = 0; w_flush_pc = '0; w_mvalid = 0; w_mdata = '0; w_ready = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        wp = 16'h8000;
        put(8'hA9, 2'd2, 16'h0044);
        put(8'h8D, 2'd3, 16'h0200);
        put(8'hEA, 2'd1, 16'h0000);
        gen(20);

        repeat (3) tick();
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 16'h8000);
        check("rst_valid", ivalid, 0);
        check("rst_opcode", opcode, 0);
        check("rst_operand", operand, 0);
        check("rst_len", len, 0);
        check("rst_count", count, 0);
        check("rst_pc", pc, 16'h8000);

        rstn = 1;
        tick();
        check("first_req", mem_req, 1);
        check("first_addr", mem_addr, 16'h8000);
        mem_valid = 1; mem_data = 24'h8D44A9;
        tick();
        mem_valid = 0;
        check("lda_valid", ivalid, 1);
        check("lda_opcode", opcode, 8'hA9);
        check("lda_operand", operand, 16'h0044);
        check("lda_len", len, 2);
        check("lda_pc", pc, 16'h8000);
        check("lda_count", count, 3);
        check("next_addr", mem_addr, 16'h8003);
        ready = 1;
        tick();
        check("sta_wait_valid", ivalid, 0);
        check("sta_wait_count", count, 1);
        check("sta_wait_pc", pc, 16'h8002);
        check("sta_wait_addr", mem_addr, 16'h8003);
        mem_valid = 1; mem_data = 24'hEA0200;
        tick();
        mem_valid = 0;
        check("sta_valid", ivalid, 1);
        check("sta_opcode", opcode, 8'h8D);
        check("sta_operand", operand, 16'h0200);
        check("sta_len", len, 3);
        check("sta_pc", pc, 16'h8002);
        auto_mem = 1; lat = 0;
        repeat (12) tick();

        // Backpressure from a clean queue
        ready = 0; flush = 1; flush_pc = 16'h9000;
        exp_q.delete(); wp = 16'h9000; gen(30);
        tick();
        flush = 0;
        repeat (12) tick();
        check("bp_count", count, 6);
        check("bp_req", mem_req, 0);
        check("bp_valid", ivalid, 1);
        check("bp_pc", pc, 16'h9000);
        ready = 1;
        tick();
        tick();
        check("bp_resume", mem_req, 1);
        repeat (18) tick();

        // Flush while a slow request is outstanding
        ready = 0; lat = 4; flush = 1; flush_pc = 16'hA000;
        exp_q.delete();
        tick();
        flush = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (mem_req && mem_addr == 16'hA000) found = 1;
        end
        check("fl_req_a000", found, 1);
        flush = 1; flush_pc = 16'hC000;
        exp_q.delete(); wp = 16'hC000; gen(40);
        tick();
        flush = 0;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            check("drain_req", mem_req, 1);
            check("drain_addr", mem_addr, 16'hA000);
            check("drain_count", count, 0);
            #2;
            if (mem_valid) found = 1;
            else tick();
        end
        check("drain_resp", found, 1);
        lat = 0;
        tick();
        check("drain_discard_count", count, 0);
        check("drain_discard_valid", ivalid, 0);
        check("drain_idle_req", mem_req, 0);
        tick();
        check("fl_new_req", mem_req, 1);
        check("fl_new_addr", mem_addr, 16'hC000);
        ready = 1;
        repeat (15) tick();

        // Flush coinciding with a response and a pop
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            #2;
            if (mem_valid && ivalid && ready) begin
                found = 1; flush = 1; flush_pc = 16'hD000;
                exp_q.delete(); wp = 16'hD000; gen(24);
            end
        end
        check("fl2_hit", found, 1);
        tick();
        flush = 0;
        check("fl2_count", count, 0);
        check("fl2_valid", ivalid, 0);
        check("fl2_pc", pc, 16'hD000);
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick();
            if (mem_req && mem_addr == 16'hD000) found = 1;
        end
        check("fl2_restart", found, 1);
        repeat (15) tick();
        ready = 0;

        // Address wrap on the instance reset to FFFE
        check("w_rst_count", w_count, 0);
        check("w_rst_pc", w_pc, 16'hFFFE);
        check("w_rst_req", w_req, 0);
        w_rstn = 1;
        tick();
        check("w_req", w_req, 1);
        check("w_addr0", w_addr, 16'hFFFE);
        w_mvalid = 1; w_mdata = 24'h44A9EA;
        tick();
        check("w_nop_valid", w_ivalid, 1);
        check("w_nop_opcode", w_opcode, 8'hEA);
        check("w_nop_len", w_len, 1);
        check("w_nop_pc", w_pc, 16'hFFFE);
        check("w_addr1", w_addr, 16'h0001);
        check("w_count3", w_count, 3);
        w_ready = 1; w_mdata = 24'h02008D;
        tick();
        w_mvalid = 0;
        check("w_lda_count", w_count, 5);
        check("w_lda_opcode", w_opcode, 8'hA9);
        check("w_lda_operand", w_operand, 16'h0044);
        check("w_lda_len", w_len, 2);
        check("w_lda_pc", w_pc, 16'hFFFF);
        check("w_addr2", w_addr, 16'h0004);
        tick();
        check("w_sta_opcode", w_opcode, 8'h8D);
        check("w_sta_operand", w_operand, 16'h0200);
        check("w_sta_len", w_len, 3);
        check("w_sta_pc", w_pc, 16'h0001);
        check("w_sta_count", w_count, 3);
        w_ready = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
